// File: rtl/wsp_pkg.sv
// rtl/wsp_pkg.sv - shared constants and control-bundle helper for the WSP sequencer
package wsp_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_IR_SHIFT   = 3'd1;
  localparam logic [2:0] ST_IR_UPDATE  = 3'd2;
  localparam logic [2:0] ST_DR_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DR_SHIFT   = 3'd4;
  localparam logic [2:0] ST_DR_UPDATE  = 3'd5;
  localparam logic [2:0] ST_DONE       = 3'd6;

  localparam logic [1:0] MODE_NOP  = 2'b00;
  localparam logic [1:0] MODE_IR   = 2'b01;
  localparam logic [1:0] MODE_DR   = 2'b10;
  localparam logic [1:0] MODE_IRDR = 2'b11;

  localparam int WIR_W = 12;
  localparam logic [WIR_W-1:0] WS_BYPASS = '0;

  typedef struct packed {
    logic select_wir;
    logic shift;
    logic capture;
    logic update;
    logic wsi;
  } wsp_ctrl_t;

  // WSP pin values for the cycle spent in state st; serial data only while shifting.
  function automatic wsp_ctrl_t ctrl_for_state(input logic [2:0] st, input logic ir_bit,
                                               input logic dr_bit);
    wsp_ctrl_t c;
    c = '0;
    case (st)
      ST_IR_SHIFT: begin
        c.select_wir = 1'b1;
        c.shift      = 1'b1;
        c.wsi        = ir_bit;
      end
      ST_IR_UPDATE: begin
        c.select_wir = 1'b1;
        c.update     = 1'b1;
      end
      ST_DR_CAPTURE: c.capture = 1'b1;
      ST_DR_SHIFT: begin
        c.shift = 1'b1;
        c.wsi   = dr_bit;
      end
      ST_DR_UPDATE: c.update = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/wsp_shift_reg.sv
// rtl/wsp_shift_reg.sv - parallel-load right-shift register exposing its next serial-out bit
module wsp_shift_reg
  import wsp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] pdata_i,
  output logic         next_sout_o
);

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = pdata_i;
    end else if (shift_i) begin
      sr_d = sr_q >> 1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // The owner registers WSI, so it needs the bit that will sit in position 0 next cycle.
  assign next_sout_o = sr_d[0];

endmodule

// File: rtl/wsp_sequencer.sv
// rtl/wsp_sequencer.sv - IEEE 1500 WSP sequencer: WIR load and run-time-length DR shift
module wsp_sequencer
  import wsp_pkg::*;
#(
  parameter int IR_W   = 12,
  parameter int DR_MAX = 64,
  parameter int LEN_W  = 7
) (
  input  logic              WRCK,
  input  logic              RESET,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [IR_W-1:0]   ir_data,
  input  logic [DR_MAX-1:0] dr_data,
  input  logic [LEN_W-1:0]  dr_len,
  output logic              busy,
  output logic              done,
  output logic [DR_MAX-1:0] dr_capt,
  output logic              SelectWIR,
  output logic              ShiftWR,
  output logic              CaptureWR,
  output logic              UpdateWR,
  output logic              WSI,
  input  logic              WSO
);

  localparam logic [LEN_W-1:0] IR_LAST = LEN_W'(IR_W - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DR_MAX);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  logic [2:0]        state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d, len_q, len_d;
  logic [1:0]        mode_q, mode_d;
  logic [DR_MAX-1:0] capt_q, capt_d;
  wsp_ctrl_t         ctrl_q, ctrl_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              accept, abort_now, ir_next, dr_next;

  assign accept    = (state_q == ST_IDLE) && start;
  // busy_q mirrors "state is between start and the last update", so abort keys off it.
  assign abort_now = abort && busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d = '0;
          case (mode)
            MODE_IR, MODE_IRDR: state_d = ST_IR_SHIFT;
            MODE_DR:            state_d = ST_DR_CAPTURE;
            default:            state_d = ST_DONE;
          endcase
        end
      end
      ST_IR_SHIFT: begin
        if (cnt_q == IR_LAST) begin
          state_d = ST_IR_UPDATE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_IR_UPDATE:  state_d = (mode_q == MODE_IRDR) ? ST_DR_CAPTURE : ST_DONE;
      ST_DR_CAPTURE: begin
        cnt_d   = '0;
        state_d = (len_q == '0) ? ST_DR_UPDATE : ST_DR_SHIFT;
      end
      ST_DR_SHIFT: begin
        if (cnt_q == len_q - ONE) begin
          state_d = ST_DR_UPDATE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_DR_UPDATE: state_d = ST_DONE;
      default:      state_d = ST_IDLE;
    endcase
    if (abort_now) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  assign mode_d = accept ? mode : mode_q;
  assign len_d  = accept ? ((dr_len > LEN_MAX) ? LEN_MAX : dr_len) : len_q;

  wsp_shift_reg #(.W(IR_W)) u_ir_sr (
    .clk_i       (WRCK),
    .rst_i       (RESET),
    .load_i      (accept),
    .shift_i     (state_q == ST_IR_SHIFT),
    .pdata_i     (ir_data),
    .next_sout_o (ir_next)
  );

  wsp_shift_reg #(.W(DR_MAX)) u_dr_sr (
    .clk_i       (WRCK),
    .rst_i       (RESET),
    .load_i      (accept),
    .shift_i     (state_q == ST_DR_SHIFT),
    .pdata_i     (dr_data),
    .next_sout_o (dr_next)
  );

  always_comb begin
    capt_d = capt_q;
    if (state_d == ST_DR_CAPTURE) begin
      capt_d = '0;
    end else if (state_q == ST_DR_SHIFT) begin
      for (int i = 0; i < DR_MAX; i++) begin
        if (cnt_q == LEN_W'(i)) begin
          capt_d[i] = WSO;
        end
      end
    end
  end

  assign ctrl_d = ctrl_for_state(state_d, ir_next, dr_next);
  assign busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
  assign done_d = (state_d == ST_DONE);

  always_ff @(posedge WRCK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= MODE_NOP;
      capt_q  <= '0;
      ctrl_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      capt_q  <= capt_d;
      ctrl_q  <= ctrl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign dr_capt   = capt_q;
  assign SelectWIR = ctrl_q.select_wir;
  assign ShiftWR   = ctrl_q.shift;
  assign CaptureWR = ctrl_q.capture;
  assign UpdateWR  = ctrl_q.update;
  assign WSI       = ctrl_q.wsi;

endmodule

// File: tb/tb_wsp_sequencer.sv
// tb/tb_wsp_sequencer.sv - directed vector bench for wsp_sequencer with a 1-bit WBY model
module tb_wsp_sequencer;
  import wsp_pkg::*;

  localparam int IR_W   = 12;
  localparam int DR_MAX = 64;
  localparam int LEN_W  = 7;

  logic              WRCK = 1'b0;
  logic              RESET = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic [IR_W-1:0]   ir_data = '0;
  logic [DR_MAX-1:0] dr_data = '0;
  logic [LEN_W-1:0]  dr_len = '0;
  logic              busy, done, SelectWIR, ShiftWR, CaptureWR, UpdateWR, WSI, WSO;
  logic [DR_MAX-1:0] dr_capt;
  logic              wby = 1'b0;
  logic [6:0]        ctl;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]        mode;
    logic [IR_W-1:0]   ir;
    logic [DR_MAX-1:0] dr;
    logic [LEN_W-1:0]  len;
    bit                hold;
    int                done_cyc;
    int                n_ir;
    logic [IR_W-1:0]   ir_s;
    int                n_dr;
    logic [DR_MAX-1:0] dr_s;
    logic [DR_MAX-1:0] capt;
    int                n_upd;
    int                n_capt;
    int                n_busy;
  } vec_t;

  vec_t vecs[5];
  vec_t rerun;

  wsp_sequencer #(.IR_W(IR_W), .DR_MAX(DR_MAX), .LEN_W(LEN_W)) dut (
    .WRCK(WRCK), .RESET(RESET), .start(start), .abort(abort), .mode(mode),
    .ir_data(ir_data), .dr_data(dr_data), .dr_len(dr_len), .busy(busy), .done(done),
    .dr_capt(dr_capt), .SelectWIR(SelectWIR), .ShiftWR(ShiftWR), .CaptureWR(CaptureWR),
    .UpdateWR(UpdateWR), .WSI(WSI), .WSO(WSO)
  );

  always #5 WRCK = ~WRCK;

  // Wrapper bypass register: capture loads 0, DR shift moves WSI in.
  assign WSO = wby;
  always @(posedge WRCK) begin
    if (CaptureWR) wby <= 1'b0;
    else if (ShiftWR && !SelectWIR) wby <= WSI;
  end

  assign ctl = {busy, done, SelectWIR, ShiftWR, CaptureWR, UpdateWR, WSI};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int done_c, n_ir, n_dr, n_upd, n_capt, n_busy, viol;
    logic [IR_W-1:0]   irs;
    logic [DR_MAX-1:0] drs;
    done_c = -1; n_ir = 0; n_dr = 0; n_upd = 0; n_capt = 0; n_busy = 0; viol = 0;
    irs = '0; drs = '0;
    @(negedge WRCK);
    mode = v.mode; ir_data = v.ir; dr_data = v.dr; dr_len = v.len; start = 1'b1;
    for (int c = 1; c <= 200 && done_c < 0; c++) begin
      @(negedge WRCK);
      if (c == 1 && !v.hold) start = 1'b0;
      if (c == 2 && v.hold) begin
        mode = ~v.mode; ir_data = ~v.ir; dr_data = ~v.dr; dr_len = 7'd3;
      end
      if (ShiftWR && SelectWIR) begin
        irs = irs | (IR_W'(WSI) << n_ir);
        n_ir++;
      end
      if (ShiftWR && !SelectWIR) begin
        drs = drs | (DR_MAX'(WSI) << n_dr);
        n_dr++;
      end
      if (!ShiftWR && WSI) viol++;
      if (UpdateWR) n_upd++;
      if (CaptureWR) n_capt++;
      if (busy) n_busy++;
      if (done) done_c = c;
    end
    chk({tag, " done_cycle"}, 64'(done_c), 64'(v.done_cyc));
    chk({tag, " ir_shift_cycles"}, 64'(n_ir), 64'(v.n_ir));
    chk({tag, " ir_wsi_stream"}, 64'(irs), 64'(v.ir_s));
    chk({tag, " dr_shift_cycles"}, 64'(n_dr), 64'(v.n_dr));
    chk({tag, " dr_wsi_stream"}, drs, v.dr_s);
    chk({tag, " dr_capt"}, dr_capt, v.capt);
    chk({tag, " update_pulses"}, 64'(n_upd), 64'(v.n_upd));
    chk({tag, " capture_pulses"}, 64'(n_capt), 64'(v.n_capt));
    chk({tag, " busy_cycles"}, 64'(n_busy), 64'(v.n_busy));
    chk({tag, " wsi_outside_shift"}, 64'(viol), 64'd0);
    @(negedge WRCK);
    chk({tag, " idle_after_done"}, 64'(ctl), 64'd0);
    start = 1'b0;
    @(negedge WRCK);
    chk({tag, " idle_second_cycle"}, 64'(ctl), 64'd0);
  endtask

  initial begin
    vecs[0] = '{mode: 2'b01, ir: 12'h801, dr: 64'h0, len: 7'd0, hold: 1'b0,
                done_cyc: 14, n_ir: 12, ir_s: 12'h801, n_dr: 0, dr_s: 64'h0,
                capt: 64'h0, n_upd: 1, n_capt: 0, n_busy: 13};
    vecs[1] = '{mode: 2'b11, ir: WS_BYPASS, dr: 64'hB, len: 7'd4, hold: 1'b0,
                done_cyc: 20, n_ir: 12, ir_s: 12'h000, n_dr: 4, dr_s: 64'hB,
                capt: 64'h6, n_upd: 2, n_capt: 1, n_busy: 19};
    vecs[2] = '{mode: 2'b10, ir: 12'hFFF, dr: 64'hFFFF, len: 7'd0, hold: 1'b0,
                done_cyc: 3, n_ir: 0, ir_s: 12'h000, n_dr: 0, dr_s: 64'h0,
                capt: 64'h0, n_upd: 1, n_capt: 1, n_busy: 2};
    vecs[3] = '{mode: 2'b00, ir: 12'h5A5, dr: 64'h1, len: 7'd5, hold: 1'b0,
                done_cyc: 1, n_ir: 0, ir_s: 12'h000, n_dr: 0, dr_s: 64'h0,
                capt: 64'h0, n_upd: 0, n_capt: 0, n_busy: 0};
    vecs[4] = '{mode: 2'b10, ir: 12'h0, dr: 64'hA5A5_0F0F_1234_8001, len: 7'd100, hold: 1'b1,
                done_cyc: 67, n_ir: 0, ir_s: 12'h000, n_dr: 64, dr_s: 64'hA5A5_0F0F_1234_8001,
                capt: 64'h4B4A_1E1E_2469_0002, n_upd: 1, n_capt: 1, n_busy: 66};

    repeat (2) @(negedge WRCK);
    chk("reset_controls", 64'(ctl), 64'd0);
    chk("reset_dr_capt", dr_capt, 64'd0);
    RESET = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Abort in cycle 5 of an IR shift, then a fresh start two cycles later.
    @(negedge WRCK);
    mode = 2'b01; ir_data = 12'h801; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge WRCK);
      if (c == 1) start = 1'b0;
    end
    chk("abort_pre_ir_shift", 64'({SelectWIR, ShiftWR}), 64'd3);
    abort = 1'b1;
    @(negedge WRCK);
    abort = 1'b0;
    chk("abort_controls", 64'(ctl), 64'd0);
    rerun = vecs[0];
    rerun.capt = 64'h4B4A_1E1E_2469_0002;
    run_op(rerun, "after_abort");

    // Asynchronous reset in the middle of a DR shift.
    @(negedge WRCK);
    mode = 2'b11; ir_data = WS_BYPASS; dr_data = 64'hB; dr_len = 7'd4; start = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge WRCK);
      if (c == 1) start = 1'b0;
    end
    chk("pre_reset_dr_shift", 64'({ShiftWR, SelectWIR}), 64'd2);
    chk("pre_reset_partial_capt", dr_capt, 64'h2);
    #2 RESET = 1'b1;
    #1;
    chk("async_reset_controls", 64'(ctl), 64'd0);
    chk("async_reset_dr_capt", dr_capt, 64'd0);
    @(negedge WRCK);
    RESET = 1'b0;
    @(negedge WRCK);
    chk("post_reset_idle", 64'(ctl), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
